// File: rtl/beat_tempo_tracker.sv
// beat_tempo_tracker
//   Takes beat candidates from an onset detector, one per spectral-flux frame.
//   It enforces a refractory window of MIN_INTERVAL frames between accepted
//   beats and times out after MAX_INTERVAL beatless frames. It also measures
//   the interval between beats and keeps a running average of the last
//   AVG_DEPTH intervals, which drives a tempo-lock flag.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   flux_valid      one-cycle frame strobe
//   beat_valid      beat candidate, sampled only with flux_valid
//   flux_value      frame flux, sampled only with flux_valid
//   beat_pulse      one-cycle pulse per accepted beat
//   beat_strength   flux_value of the last accepted beat
//   last_interval   frames between the last two accepted beats
//   interval_valid  one-cycle pulse when last_interval updates
//   avg_interval    mean of the stored intervals
//   tempo_locked    high while the stored intervals are full and tightly spread
//   beat_count      accepted beats, modulo 2^16
module beat_tempo_tracker #(
  parameter int unsigned MAX_FLUX_LENGTH = 32,
  parameter int unsigned INT_W           = 8,
  parameter int unsigned MIN_INTERVAL    = 8,
  parameter int unsigned MAX_INTERVAL    = 255,
  parameter int unsigned AVG_DEPTH       = 4,
  parameter int unsigned LOCK_TOL        = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flux_valid,
  input  logic                       beat_valid,
  input  logic [MAX_FLUX_LENGTH-1:0] flux_value,
  output logic                       beat_pulse,
  output logic [MAX_FLUX_LENGTH-1:0] beat_strength,
  output logic [INT_W-1:0]           last_interval,
  output logic                       interval_valid,
  output logic [INT_W-1:0]           avg_interval,
  output logic                       tempo_locked,
  output logic [15:0]                beat_count
);

  localparam int unsigned AVG_SHIFT = $clog2(AVG_DEPTH);
  localparam int unsigned SUM_W     = INT_W + AVG_SHIFT;
  localparam int unsigned PTR_W     = AVG_SHIFT;
  localparam int unsigned CNT_W     = $clog2(AVG_DEPTH + 1);

  localparam logic [INT_W-1:0] ARM_AT     = INT_W'(MIN_INTERVAL - 1);
  localparam logic [INT_W-1:0] TIMEOUT_AT = INT_W'(MAX_INTERVAL);
  localparam logic [CNT_W-1:0] HIST_FULL  = CNT_W'(AVG_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REFRACTORY,
    ARMED
  } state_t;

  state_t            state_q, state_d;
  logic [INT_W-1:0]  frame_cnt;
  logic [INT_W-1:0]  frame_next;
  logic              accept;
  logic              has_interval;
  logic              timeout;

  logic [INT_W-1:0]  hist [AVG_DEPTH];
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  hist_cnt;
  logic [PTR_W-1:0]  wr_ptr;

  logic [INT_W-1:0]  hist_max;
  logic [INT_W-1:0]  hist_min;
  logic [INT_W-1:0]  spread;
  logic              lock_ok;

  // The interval in the current frame is the frame count plus one.
  assign frame_next = frame_cnt + 1'b1;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        frame_cnt <= '0;
      end else if (flux_valid && (state_q != IDLE)) begin
        frame_cnt <= frame_next;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    has_interval = 1'b0;
    timeout      = 1'b0;
    if (flux_valid) begin
      unique case (state_q)
        IDLE: begin
          if (beat_valid) begin
            accept  = 1'b1;
            state_d = REFRACTORY;
          end
        end
        REFRACTORY: begin
          if (frame_next == ARM_AT) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          // A beat in the frame that reaches MAX_INTERVAL wins over the timeout.
          if (beat_valid) begin
            accept       = 1'b1;
            has_interval = 1'b1;
            state_d      = REFRACTORY;
          end else if (frame_next == TIMEOUT_AT) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ------------------------------------------------- history spread check
  always_comb begin
    hist_max = hist[0];
    hist_min = hist[0];
    for (int unsigned i = 1; i < AVG_DEPTH; i++) begin
      if (hist[PTR_W'(i)] > hist_max) hist_max = hist[PTR_W'(i)];
      if (hist[PTR_W'(i)] < hist_min) hist_min = hist[PTR_W'(i)];
    end
    spread  = hist_max - hist_min;
    lock_ok = (hist_cnt == HIST_FULL) && (32'(spread) <= LOCK_TOL);
  end

  // ------------------------------------------------------------ datapath
  // Accept-side updates land one cycle after the accept. avg_interval and
  // tempo_locked are re-registered from the updated history every cycle, so
  // they follow one cycle later. A timeout also forces tempo_locked low right
  // away.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_pulse     <= 1'b0;
      beat_strength  <= '0;
      last_interval  <= '0;
      interval_valid <= 1'b0;
      avg_interval   <= '0;
      tempo_locked   <= 1'b0;
      beat_count     <= '0;
      sum            <= '0;
      hist_cnt       <= '0;
      wr_ptr         <= '0;
      for (int unsigned i = 0; i < AVG_DEPTH; i++) begin
        hist[PTR_W'(i)] <= '0;
      end
    end else begin
      beat_pulse     <= accept;
      interval_valid <= has_interval;
      avg_interval   <= INT_W'(sum >> AVG_SHIFT);
      tempo_locked   <= lock_ok;

      if (accept) begin
        beat_strength <= flux_value;
        beat_count    <= beat_count + 16'd1;
      end

      if (has_interval) begin
        last_interval <= frame_next;
        hist[wr_ptr]  <= frame_next;
        // Slots not yet written hold zero, so subtracting the oldest slot is
        // correct during fill-up as well.
        sum           <= sum - SUM_W'(hist[wr_ptr]) + SUM_W'(frame_next);
        wr_ptr        <= wr_ptr + 1'b1;
        if (hist_cnt != HIST_FULL) begin
          hist_cnt <= hist_cnt + 1'b1;
        end
      end

      if (timeout) begin
        tempo_locked <= 1'b0;
        sum          <= '0;
        hist_cnt     <= '0;
        wr_ptr       <= '0;
        for (int unsigned i = 0; i < AVG_DEPTH; i++) begin
          hist[PTR_W'(i)] <= '0;
        end
      end
    end
  end

endmodule

// File: doc/beat_tempo_tracker.md
BEAT_TEMPO_TRACKER -- requirements
Module: beat_tempo_tracker

Interface
REQ-001 Parameter MAX_FLUX_LENGTH, default 32: width of the flux_value input and of beat_strength.
REQ-002 Parameter INT_W, default 8: width of every interval quantity.
REQ-003 Parameter MIN_INTERVAL, default 8: minimum frames between accepted beats; SHALL satisfy 2 <= MIN_INTERVAL < MAX_INTERVAL.
REQ-004 Parameter MAX_INTERVAL, default 255: timeout in frames; SHALL be <= 2^INT_W-1.
REQ-005 Parameter AVG_DEPTH, default 4: number of intervals averaged; SHALL be a power of two >= 2.
REQ-006 Parameter LOCK_TOL, default 2: maximum allowed spread (max-min) of stored intervals for lock.
REQ-007 clk  input  1  clock; single clock domain; all logic on the rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 flux_valid  input  1  one-cycle frame strobe from the spectral-flux stage.
REQ-010 beat_valid  input  1  beat candidate; sampled only when flux_valid=1.
REQ-011 flux_value  input  MAX_FLUX_LENGTH  frame flux; sampled only when flux_valid=1.
REQ-012 beat_pulse  output  1  one-cycle pulse per accepted beat.
REQ-013 beat_strength  output  MAX_FLUX_LENGTH  flux_value of the last accepted beat.
REQ-014 last_interval  output  INT_W  frames between the last two accepted beats.
REQ-015 interval_valid  output  1  one-cycle pulse when last_interval updates.
REQ-016 avg_interval  output  INT_W  mean of stored intervals, equal to sum >> log2(AVG_DEPTH).
REQ-017 tempo_locked  output  1  level; high while tempo is stable.
REQ-018 beat_count  output  16  count of accepted beats, wrapping modulo 2^16.

Function
REQ-019 FSM states SHALL be IDLE, REFRACTORY and ARMED; the FSM SHALL act only in cycles where flux_valid=1 and hold otherwise.
REQ-020 frame_cnt (INT_W bits) SHALL be cleared on every accepted beat and otherwise incremented by 1 on each flux_valid frame in REFRACTORY or ARMED.
REQ-021 IDLE, on flux_valid and beat_valid: accept the beat, go to REFRACTORY, set frame_cnt=0, no interval produced.
REQ-022 REFRACTORY, on flux_valid: beat_valid is ignored; when frame_cnt+1 == MIN_INTERVAL-1, go to ARMED.
REQ-023 ARMED, on flux_valid and beat_valid: accept the beat, interval=frame_cnt+1 (>= MIN_INTERVAL), go to REFRACTORY, frame_cnt=0.
REQ-024 ARMED, on flux_valid, no beat and frame_cnt+1 == MAX_INTERVAL: timeout, go to IDLE.
REQ-025 A beat in the same frame that reaches MAX_INTERVAL SHALL be accepted with interval=MAX_INTERVAL and SHALL NOT time out.
REQ-026 Accept in cycle T: at T+1, beat_pulse=1, beat_strength=flux_value(T), beat_count+=1.
REQ-027 If the accept at T produces an interval, then at T+1 last_interval=interval and interval_valid=1.
REQ-028 Same case at T+1: the interval is written to the circular history, running sum = sum - oldest + interval, and hist_cnt increments, saturating at AVG_DEPTH.
REQ-029 At T+2, avg_interval SHALL equal sum >> log2(AVG_DEPTH).
REQ-030 At T+2, tempo_locked SHALL be 1 only if hist_cnt == AVG_DEPTH and (max - min) over the history <= LOCK_TOL; otherwise 0.
REQ-031 Timeout at T: at T+1, history entries, sum and hist_cnt SHALL clear and tempo_locked=0; at T+2, avg_interval=0. beat_count and last_interval SHALL hold.
REQ-032 The sum register SHALL be INT_W+log2(AVG_DEPTH) bits wide and SHALL NOT overflow.
REQ-033 beat_pulse and interval_valid SHALL be high for exactly one cycle per accept.
REQ-034 Back-to-back flux_valid strobes on consecutive cycles SHALL be handled with no lost frames.

Reset
REQ-035 Reset SHALL force state=IDLE and frame_cnt=0, and clear the history, sum and hist_cnt.
REQ-036 Reset SHALL force all outputs to 0.
REQ-037 Reset asserted mid-pipeline SHALL suppress any pending T+1/T+2 update.
REQ-038 Reset SHALL take priority over flux_valid in the same cycle.

Verification
REQ-039 Steady tempo: beats every 10 frames with MIN_INTERVAL=8 -> from the 2nd beat on, last_interval=10 and interval_valid pulses; after the 5th beat, avg_interval=10 and tempo_locked=1.
REQ-040 Refractory: beats at frames 0, 3, 8 -> the frame-3 beat is ignored, the frame-8 beat is accepted with last_interval=8, and beat_count=2.
REQ-041 Timeout: one beat then 255 beatless frames -> IDLE, tempo_locked=0, avg_interval=0; the next beat gives beat_pulse=1 and interval_valid=0.
REQ-042 Boundary: beat exactly at frame_cnt+1=255 -> accepted with last_interval=255 and no timeout.
REQ-043 Jitter: intervals 10, 12, 10, 14 -> tempo_locked=0 (spread 4 > 2); a following 11, 11, 12, 11 -> tempo_locked=1 and avg_interval=11.
REQ-044 Reset asserted the cycle after an accept -> no beat_pulse or interval_valid, and all outputs read 0.
